// File: rtl/adpll_phase_det.sv
// ---------------------------------------------------------------------------
// adpll_phase_det
//
// Phase detector between the TDC front end and the ADPLL loop filter.
// Every reference cycle it samples the TDC ripple count and fractional phase
// to form the variable (CKV) phase. It accumulates FCW to form the reference
// phase and outputs the wrap-corrected signed difference of the two. It also
// qualifies phase lock with separate lock and unlock run-length counters.
//
// Ports:
//   clk              32 MHz reference clock
//   rst              asynchronous reset, active-high
//   en               block enable; low returns the block to IDLE
//   FCW[25:0]        channel word, f_ckv/f_ref in Q7.19
//   tdc_ripple_count CKV edge count modulo 128
//   tdc_phase[15:0]  fractional CKV phase at the clk edge, unsigned Q0.16
//   phase_err[25:0]  signed phase error, Q7.19 two's complement
//   err_valid        phase_err holds a valid tracking sample
//   lock             phase lock qualified
//   state[1:0]       0=IDLE, 1=ALIGN, 2=TRACK
// ---------------------------------------------------------------------------
module adpll_phase_det #(
    parameter int ALIGN_CYC  = 4,
    parameter int LOCK_THR   = 8192,
    parameter int LOCK_CNT   = 16,
    parameter int UNLOCK_CNT = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic [25:0] FCW,
    input  logic [6:0]  tdc_ripple_count,
    input  logic [15:0] tdc_phase,
    output logic [25:0] phase_err,
    output logic        err_valid,
    output logic        lock,
    output logic [1:0]  state
);

    localparam int ALIGN_W = (ALIGN_CYC < 1) ? 1 : $clog2(ALIGN_CYC + 1);
    localparam int CNT_MAX = (LOCK_CNT > UNLOCK_CNT) ? LOCK_CNT : UNLOCK_CNT;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ALIGN = 2'd1,
        TRACK = 2'd2
    } state_t;

    state_t               state_q;
    state_t               state_next;
    logic [25:0]          pv_q;
    logic [25:0]          pr;
    logic [25:0]          fcw_q;
    logic [ALIGN_W-1:0]   align_cnt;
    logic [CNT_W-1:0]     in_cnt;
    logic [CNT_W-1:0]     out_cnt;

    logic [25:0]          pv_now;
    logic                 fcw_change;
    logic                 align_done;
    logic [25:0]          err_mag;
    logic                 err_in;
    logic [CNT_W-1:0]     in_next;
    logic [CNT_W-1:0]     out_next;

    assign pv_now     = {tdc_ripple_count, tdc_phase, 3'b000};
    assign fcw_change = (FCW != fcw_q);
    assign align_done = (align_cnt == ALIGN_W'(ALIGN_CYC - 1));
    assign state      = state_q;

    // Magnitude of the registered error. The most negative code negates to
    // itself, which as an unsigned value is 2^25 and so always lands out of
    // the lock window.
    always_comb begin
        err_mag  = phase_err[25] ? (~phase_err + 26'd1) : phase_err;
        err_in   = (err_mag <= 26'(LOCK_THR));
        in_next  = '0;
        out_next = '0;
        if (err_in) begin
            in_next = (in_cnt == CNT_W'(CNT_MAX)) ? in_cnt : in_cnt + 1'b1;
        end else begin
            out_next = (out_cnt == CNT_W'(CNT_MAX)) ? out_cnt : out_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_next;
        end
    end

    // Enable has priority over a channel change; a channel change in either
    // active state restarts alignment.
    always_comb begin
        state_next = state_q;
        case (state_q)
            IDLE: begin
                if (en) state_next = ALIGN;
            end
            ALIGN: begin
                if (!en)             state_next = IDLE;
                else if (fcw_change) state_next = ALIGN;
                else if (align_done) state_next = TRACK;
            end
            TRACK: begin
                if (!en)             state_next = IDLE;
                else if (fcw_change) state_next = ALIGN;
            end
            default: state_next = IDLE;
        endcase
    end

    // Phase datapath and lock qualifier. The reference phase is seeded from
    // the last captured TDC sample plus one FCW step, so an ideal CKV gives a
    // zero error from the first tracking compare onward.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pv_q      <= '0;
            pr        <= '0;
            fcw_q     <= '0;
            align_cnt <= '0;
            in_cnt    <= '0;
            out_cnt   <= '0;
            phase_err <= '0;
            err_valid <= 1'b0;
            lock      <= 1'b0;
        end else begin
            if (state_q != IDLE) pv_q <= pv_now;

            if (state_q == IDLE || !en || fcw_change) begin
                pr        <= '0;
                align_cnt <= '0;
                in_cnt    <= '0;
                out_cnt   <= '0;
                phase_err <= '0;
                err_valid <= 1'b0;
                lock      <= 1'b0;
                if (state_q == IDLE) begin
                    if (en) fcw_q <= FCW;
                end else if (!en) begin
                    fcw_q <= '0;
                end else begin
                    fcw_q <= FCW;
                end
            end else if (state_q == ALIGN) begin
                if (align_done) begin
                    pr        <= pv_q + fcw_q;
                    align_cnt <= '0;
                end else begin
                    align_cnt <= align_cnt + 1'b1;
                end
            end else begin
                pr        <= pr + fcw_q;
                phase_err <= pr - pv_q;
                err_valid <= 1'b1;
                if (err_valid) begin
                    if (!lock) begin
                        out_cnt <= '0;
                        if (in_next >= CNT_W'(LOCK_CNT)) begin
                            lock   <= 1'b1;
                            in_cnt <= '0;
                        end else begin
                            in_cnt <= in_next;
                        end
                    end else begin
                        in_cnt <= '0;
                        if (out_next >= CNT_W'(UNLOCK_CNT)) begin
                            lock    <= 1'b0;
                            out_cnt <= '0;
                        end else begin
                            out_cnt <= out_next;
                        end
                    end
                end
            end
        end
    end

endmodule
